main_control_fsm: RTL and testbench

//  Multicycle main control unit of the 16-bit CPU. It sits directly upstream of ALUcontrol.
//  It sequences fetch/decode/execute/memory/writeback, owns the memory-fetch handshake and

---
 rtl/main_control_fsm_if.sv | 16 +
 rtl/main_control_fsm.sv | 194 +++++++++++++++++++
 tb/tb_main_control_fsm.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/main_control_fsm_if.sv
// Memory-fetch bus between the main control unit and instruction/data memory.
//
// Handshake: the controller raises mem_req (with mem_we selecting store vs. load)
// and holds it, unchanged, until memory answers with mem_ready. The transfer
// completes on the rising edge where mem_req and mem_ready are both high. instr
// carries the read data and is sampled on that edge. mem_ready seen while mem_req
// is low carries no meaning and is ignored.
interface main_control_fsm_if;
  logic [15:0] instr;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;

  modport master (output mem_req, output mem_we, input instr, input mem_ready);
  modport slave  (input mem_req, input mem_we, output instr, output mem_ready);
endinterface

// File: rtl/main_control_fsm.sv
// Multicycle main control unit of the 16-bit CPU. Sequences
// fetch/decode/execute/memory/writeback, owns the memory handshake, drives the
// datapath enables and hands registered op/func fields to ALUcontrol.
module main_control_fsm #(
  parameter int TIMEOUT = 255,  // max cycles waiting for mem_ready before bus_err
  parameter int CNT_W   = 8     // wait counter width, must hold TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,      // asynchronous, active low
  main_control_fsm_if.master  mem,
  input  logic                alu_zero,
  output logic [3:0]          op,
  output logic [3:0]          func,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                reg_write,
  output logic                reg_dst,
  output logic [1:0]          wb_sel,
  output logic                illegal,
  output logic                bus_err,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [3:0]       func_q, func_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_req_c, mem_we_c;
  logic             timed_out;
  logic             is_eq_branch;
  logic             unused_instr;

  // Only op and func are decoded here; the remaining fields feed the datapath.
  assign unused_instr = ^mem.instr[11:4];

  assign timed_out    = (cnt_q == CNT_W'(TIMEOUT));
  // beq (op2) and the op0 func10 form branch on zero; op3 / func11 branch on non-zero.
  assign is_eq_branch = (op_q == 4'd2) || ((op_q == 4'd0) && (func_q == 4'd10));

  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;
  assign state       = state_q;
  assign op          = op_q;
  assign func        = func_q;

  // State, latched instruction fields and memory wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      op_q    <= 4'd0;
      func_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decode and datapath controls; everything low while reset is held.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    func_d    = func_q;
    cnt_d     = '0;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    wb_sel    = 2'b00;
    illegal   = 1'b0;
    bus_err   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = 2'b01;           // PC + 2
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          op_d     = mem.instr[15:12];
          func_d   = mem.instr[3:0];
          state_d  = S_DECODE;
        end else if (timed_out) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'b11;           // precompute branch target
        state_d   = S_FETCH;
        case (op_q)
          4'd0: begin
            case (func_q)
              4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd9: state_d = S_EXEC;
              4'd6:                               state_d = S_WB;
              4'd7: begin
                pc_write = 1'b1;
                pc_src   = 2'b11;
              end
              4'd10, 4'd11:                       state_d = S_BRANCH;
              default:                            illegal = 1'b1;
            endcase
          end
          4'd1, 4'd5, 4'd6, 4'd9, 4'd10, 4'd11,
          4'd12, 4'd13, 4'd14, 4'd15:            state_d = S_EXEC;
          4'd2, 4'd3:                            state_d = S_BRANCH;
          4'd4: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
          end
          4'd8:                                  state_d = S_WB;
          default:                               illegal = 1'b1;
        endcase
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = (op_q == 4'd0) ? 2'b00 : 2'b10;
        state_d   = ((op_q == 4'd5) || (op_q == 4'd6)) ? S_MEM : S_WB;
      end

      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = (op_q == 4'd6);
        if (mem.mem_ready) begin
          state_d = (op_q == 4'd6) ? S_FETCH : S_WB;
        end else if (timed_out) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = (op_q == 4'd0);
        if (op_q == 4'd5)                              wb_sel = 2'b01;
        else if (op_q == 4'd8)                         wb_sel = 2'b10;
        else if ((op_q == 4'd0) && (func_q == 4'd6))   wb_sel = 2'b11;
        else                                           wb_sel = 2'b00;
        state_d = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        pc_src    = 2'b01;
        pc_write  = is_eq_branch ? alu_zero : ~alu_zero;
        state_d   = S_FETCH;
      end

      default: state_d = S_FETCH;    // unused encodings recover
    endcase

    if (!reset) begin
      mem_req_c = 1'b0;
      mem_we_c  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      reg_write = 1'b0;
      reg_dst   = 1'b0;
      wb_sel    = 2'b00;
      illegal   = 1'b0;
      bus_err   = 1'b0;
    end
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: each step drives inputs, pushes the
// expected output vector and compares it against the DUT mid-cycle.
module tb_main_control_fsm;

  logic        clk;
  logic        reset;
  logic        alu_zero;
  logic [3:0]  op, func;
  logic        ir_write, pc_write, alu_src_a, reg_write, reg_dst, illegal, bus_err;
  logic [1:0]  pc_src, alu_src_b, wb_sel;
  logic [2:0]  state;

  main_control_fsm_if mem_if ();

  main_control_fsm #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem       (mem_if.master),
    .alu_zero  (alu_zero),
    .op        (op),
    .func      (func),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .wb_sel    (wb_sel),
    .illegal   (illegal),
    .bus_err   (bus_err),
    .state     (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [25:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [25:0] obs;

  assign obs = {state, op, func, ir_write, pc_write, pc_src, mem_if.mem_req, mem_if.mem_we,
                alu_src_a, alu_src_b, reg_write, reg_dst, wb_sel, illegal, bus_err};

  // Field order: state op func ir_w pc_w pc_src req we src_a src_b reg_w reg_dst wb_sel illegal bus_err
  function automatic logic [25:0] ev(input logic [2:0] st, input logic [3:0] o, input logic [3:0] f,
                                     input logic irw, input logic pcw, input logic [1:0] pcs,
                                     input logic mr, input logic mw, input logic sa,
                                     input logic [1:0] sb, input logic rw, input logic rd,
                                     input logic [1:0] wb, input logic il, input logic be);
    return {st, o, f, irw, pcw, pcs, mr, mw, sa, sb, rw, rd, wb, il, be};
  endfunction

  task automatic compare(input string tag);
    logic [25:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s scoreboard empty obs=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s obs=%h exp=%h", tag, obs, e);
      end
    end
  endtask

  // Driver: apply inputs for one cycle and check outputs mid-cycle.
  task automatic cyc(input string tag, input logic [15:0] ins, input logic rdy, input logic az,
                     input logic [25:0] e);
    mem_if.instr     = ins;
    mem_if.mem_ready = rdy;
    alu_zero         = az;
    exp_q.push_back(e);
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string tag, input logic [25:0] e);
    exp_q.push_back(e);
    compare(tag);
  endtask

  initial begin
    reset            = 1'b0;
    mem_if.instr     = 16'h0000;
    mem_if.mem_ready = 1'b0;
    alu_zero         = 1'b0;
    #3;
    check_now("reset_state", ev(0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0));
    @(posedge clk); #1;
    reset = 1'b1;
    cyc("fetch_idle", 16'h0000, 0, 0, ev(0,0,0, 0,0,0, 1,0,0,1, 0,0,0,0,0));

    // add
    cyc("add_fetch",  16'h0120, 1, 0, ev(0,0,0, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("add_decode", 16'h0000, 1, 0, ev(1,0,0, 0,0,0, 0,0,0,3, 0,0,0,0,0));
    cyc("add_exec",   16'h0000, 1, 0, ev(2,0,0, 0,0,0, 0,0,1,0, 0,0,0,0,0));
    cyc("add_wb",     16'h0000, 0, 0, ev(4,0,0, 0,0,0, 0,0,0,0, 1,1,0,0,0));

    // lw with memory stalled for 3 cycles
    cyc("lw_fetch",   16'h5123, 1, 0, ev(0,0,0, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("lw_decode",  16'h0000, 0, 0, ev(1,5,3, 0,0,0, 0,0,0,3, 0,0,0,0,0));
    cyc("lw_exec",    16'h0000, 0, 0, ev(2,5,3, 0,0,0, 0,0,1,2, 0,0,0,0,0));
    for (int i = 0; i < 3; i++)
      cyc("lw_mem_wait", 16'h0000, 0, 0, ev(3,5,3, 0,0,0, 1,0,0,0, 0,0,0,0,0));
    cyc("lw_mem_done", 16'h0000, 1, 0, ev(3,5,3, 0,0,0, 1,0,0,0, 0,0,0,0,0));
    cyc("lw_wb",       16'h0000, 0, 0, ev(4,5,3, 0,0,0, 0,0,0,0, 1,0,1,0,0));

    // sw
    cyc("sw_fetch",   16'h6000, 1, 0, ev(0,5,3, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("sw_decode",  16'h0000, 0, 0, ev(1,6,0, 0,0,0, 0,0,0,3, 0,0,0,0,0));
    cyc("sw_exec",    16'h0000, 0, 0, ev(2,6,0, 0,0,0, 0,0,1,2, 0,0,0,0,0));
    cyc("sw_mem",     16'h0000, 1, 0, ev(3,6,0, 0,0,0, 1,1,0,0, 0,0,0,0,0));

    // beq taken / not taken
    cyc("beq_fetch",  16'h2004, 1, 0, ev(0,6,0, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("beq_decode", 16'h0000, 0, 0, ev(1,2,4, 0,0,0, 0,0,0,3, 0,0,0,0,0));
    cyc("beq_taken",  16'h0000, 0, 1, ev(5,2,4, 0,1,1, 0,0,1,0, 0,0,0,0,0));
    cyc("beq_fetch2", 16'h2004, 1, 0, ev(0,2,4, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("beq_decode2",16'h0000, 0, 0, ev(1,2,4, 0,0,0, 0,0,0,3, 0,0,0,0,0));
    cyc("beq_not",    16'h0000, 0, 0, ev(5,2,4, 0,0,1, 0,0,1,0, 0,0,0,0,0));

    // bnez not taken / taken
    cyc("bnez_fetch", 16'h3000, 1, 0, ev(0,2,4, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("bnez_decode",16'h0000, 0, 0, ev(1,3,0, 0,0,0, 0,0,0,3, 0,0,0,0,0));
    cyc("bnez_not",   16'h0000, 0, 1, ev(5,3,0, 0,0,1, 0,0,1,0, 0,0,0,0,0));
    cyc("bnez_fetch2",16'h3000, 1, 0, ev(0,3,0, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("bnez_decode2",16'h0000,0, 0, ev(1,3,0, 0,0,0, 0,0,0,3, 0,0,0,0,0));
    cyc("bnez_taken", 16'h0000, 0, 0, ev(5,3,0, 0,1,1, 0,0,1,0, 0,0,0,0,0));

    // op0 func10 branch-on-zero
    cyc("bz10_fetch", 16'h000A, 1, 0, ev(0,3,0, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("bz10_decode",16'h0000, 0, 0, ev(1,0,10, 0,0,0, 0,0,0,3, 0,0,0,0,0));
    cyc("bz10_taken", 16'h0000, 0, 1, ev(5,0,10, 0,1,1, 0,0,1,0, 0,0,0,0,0));

    // jump, jr
    cyc("j_fetch",    16'h4ABC, 1, 0, ev(0,0,10, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("j_decode",   16'h0000, 0, 0, ev(1,4,12, 0,1,2, 0,0,0,3, 0,0,0,0,0));
    cyc("jr_fetch",   16'h0007, 1, 0, ev(0,4,12, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("jr_decode",  16'h0000, 0, 0, ev(1,0,7, 0,1,3, 0,0,0,3, 0,0,0,0,0));

    // li, copy
    cyc("li_fetch",   16'h8005, 1, 0, ev(0,0,7, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("li_decode",  16'h0000, 0, 0, ev(1,8,5, 0,0,0, 0,0,0,3, 0,0,0,0,0));
    cyc("li_wb",      16'h0000, 0, 0, ev(4,8,5, 0,0,0, 0,0,0,0, 1,0,2,0,0));
    cyc("cp_fetch",   16'h0106, 1, 0, ev(0,8,5, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("cp_decode",  16'h0000, 0, 0, ev(1,0,6, 0,0,0, 0,0,0,3, 0,0,0,0,0));
    cyc("cp_wb",      16'h0000, 0, 0, ev(4,0,6, 0,0,0, 0,0,0,0, 1,1,3,0,0));

    // illegal encodings
    cyc("ill7_fetch", 16'h7000, 1, 0, ev(0,0,6, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("ill7_decode",16'h0000, 1, 1, ev(1,7,0, 0,0,0, 0,0,0,3, 0,0,0,1,0));
    cyc("ill5_fetch", 16'h0005, 1, 0, ev(0,7,0, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("ill5_decode",16'h0000, 0, 0, ev(1,0,5, 0,0,0, 0,0,0,3, 0,0,0,1,0));

    // fetch timeout
    for (int i = 0; i < 4; i++)
      cyc("fetch_wait", 16'h0000, 0, 0, ev(0,0,5, 0,0,0, 1,0,0,1, 0,0,0,0,0));
    cyc("fetch_buserr", 16'h0000, 0, 0, ev(0,0,5, 0,0,0, 1,0,0,1, 0,0,0,0,1));
    cyc("fetch_after",  16'h0000, 0, 0, ev(0,0,5, 0,0,0, 1,0,0,1, 0,0,0,0,0));

    // store timeout in MEM
    cyc("swto_fetch", 16'h6000, 1, 0, ev(0,0,5, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("swto_decode",16'h0000, 0, 0, ev(1,6,0, 0,0,0, 0,0,0,3, 0,0,0,0,0));
    cyc("swto_exec",  16'h0000, 0, 0, ev(2,6,0, 0,0,0, 0,0,1,2, 0,0,0,0,0));
    for (int i = 0; i < 4; i++)
      cyc("swto_wait", 16'h0000, 0, 0, ev(3,6,0, 0,0,0, 1,1,0,0, 0,0,0,0,0));
    cyc("swto_buserr", 16'h0000, 0, 0, ev(3,6,0, 0,0,0, 1,1,0,0, 0,0,0,0,1));
    cyc("swto_fetch2", 16'h0000, 0, 0, ev(0,6,0, 0,0,0, 1,0,0,1, 0,0,0,0,0));

    // reset in the middle of EXEC
    cyc("rst_fetch",  16'h0123, 1, 0, ev(0,6,0, 1,1,0, 1,0,0,1, 0,0,0,0,0));
    cyc("rst_decode", 16'h0000, 0, 0, ev(1,0,3, 0,0,0, 0,0,0,3, 0,0,0,0,0));
    check_now("rst_in_exec", ev(2,0,3, 0,0,0, 0,0,1,0, 0,0,0,0,0));
    reset = 1'b0;
    #2;
    check_now("rst_async", ev(0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0));
    @(posedge clk); #1;
    check_now("rst_held", ev(0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0));
    reset = 1'b1;
    cyc("rst_release", 16'h0000, 0, 0, ev(0,0,0, 0,0,0, 1,0,0,1, 0,0,0,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
